sync_edge_filter: RTL and testbench
===================================

// Module: sync_edge_filter
// PURPOSE
//   Multi-channel input conditioner for asynchronous level signals (GPIO, IRQ lines, straps).
//   Per channel: STAGES-deep synchroniser, DEBOUNCE-cycle stability filter, rise/fall edge
//   detection, per-channel edge-mode select, sticky pending flag with acknowledge.
//   Sits between pads/foreign-domain levels and a register file or interrupt controller.
// PARAMETERS
//   NUM_CH    8  number of independent channels, >=1
//   STAGES    2  synchroniser flops per channel, >=2
//   DEBOUNCE  1  consecutive enabled cycles a new synced level must persist before acceptance, >=1
// PORTS
//   clk_i       in   1         single clock; all logic in this domain
//   rst_i       in   1         reset, synchronous, active-high
//   clr_i       in   1         synchronous clear, same effect as rst_i
//   en_i        in   1         filter/event enable
//   serial_i    in   NUM_CH    asynchronous input levels
//   mode_i      in   2*NUM_CH  per-channel edge_mode_e: 00 NONE, 01 RISE, 10 FALL, 11 BOTH
//   ack_i       in   NUM_CH    per-channel pending clear, pulse
//   serial_o    out  NUM_CH    filtered level
//   r_edge_o    out  NUM_CH    rising-edge pulse, unmasked by mode
//   f_edge_o    out  NUM_CH    falling-edge pulse, unmasked by mode
//   event_o     out  NUM_CH    edge pulse qualified by mode_i
//   pending_o   out  NUM_CH    sticky event flag
//   irq_o       out  1         |pending_o
// BEHAVIOUR
//   Reset/clear: every flop is 0, i.e. sync chain, counters, filt_q and pending_q.
//     All outputs are therefore 0.
//   Sync chain: shifts every clock regardless of en_i. s[i] is the last stage.
//   Filter state: filt_q[i] drives serial_o[i]; cnt_q[i] is $clog2(DEBOUNCE+1) bits wide.
//     s==filt_q                     -> cnt_q <= 0.
//     s!=filt_q, en_i, cnt_q<DEB-1  -> cnt_q <= cnt_q+1.
//     s!=filt_q, en_i, cnt_q==DEB-1 -> accept: filt_q <= s, cnt_q <= 0.
//     en_i=0                        -> filt_q and cnt_q hold.
//   Glitch rejection: a mismatch that returns to filt_q before acceptance restarts the count from 0.
//   Edges: combinational from flops only, no input-to-output path.
//     r_edge_o = accept & s
//     f_edge_o = accept & ~s
//     Each is high exactly in the cycle before filt_q changes.
//   event_o[i] = (r_edge & mode[0]) | (f_edge & mode[1]). mode_i is sampled live.
//   pending_q[i] <= event_o[i] | (pending_q[i] & ~ack_i[i]). Simultaneous event and ack: event wins, flag stays set.
//   ack_i is honoured when en_i=0; events cannot occur while en_i=0.
//   Latency: E0 is the first edge sampling a new stable level.
//     edge/event pulse is visible after edge E0+STAGES+DEBOUNCE-2.
//     serial_o and pending_o update at edge E0+STAGES+DEBOUNCE-1.
//     DEBOUNCE=1 reduces the block to a plain sync + edge detector.
//   Reset or clr_i mid-count: the count is discarded. After release the block re-qualifies from filt_q=0.
//     A channel held high comes out of reset with a normal debounced rising edge.
// STRUCTURE
//   sync_edge_filter_pkg:
//     typedef enum logic [1:0] edge_mode_e {EDGE_NONE, EDGE_RISE, EDGE_FALL, EDGE_BOTH}
//     helper function cnt_width(DEBOUNCE)
//   Sub-module sync_edge_filter_ch: one channel (sync chain, counter, filt_q, pending_q, edge logic).
//     Instantiated NUM_CH times in a generate loop.
//     The top adds only irq_o reduction and port slicing.
//   Reset is synchronous throughout. No clock gating cell.
// TESTING
//   Default config, NUM_CH=8 STAGES=2 DEBOUNCE=3, unless stated otherwise.
//   1 Basic path: serial_i[0] 0->1 before E0, mode=RISE.
//     -> r_edge_o[0]=event_o[0]=1 for exactly one cycle after E0+3.
//     -> serial_o[0]=1 and pending_o[0]=irq_o=1 at E0+4.
//     -> f_edge_o stays 0.
//   2 Glitch reject: serial_i[1] high for 2 cycles, then low.
//     -> no edge, serial_o[1] stays 0.
//     -> a 3-cycle-wide synced pulse is accepted: rise, then fall 3 cycles later.
//   3 Mode mask: ch2 mode=FALL, full 0->1->0.
//     -> r_edge_o and f_edge_o both pulse, event_o only on the fall.
//     -> with mode=NONE, pending_o[2] never sets.
//   4 Ack race: ack_i[3] in the same cycle as event_o[3] -> pending_o[3] remains 1.
//     -> ack one cycle later -> 0.
//     -> irq_o falls only when all pending bits are clear.
//   5 Enable/clear: en_i=0 during a change -> serial_o holds, no edges.
//     -> en_i=1 -> acceptance DEBOUNCE enabled cycles after the sync output shows the mismatch.
//     -> clr_i mid-count -> all outputs 0 next cycle; a held-high input re-qualifies.
//   6 Bypass: DEBOUNCE=1, STAGES=3 -> edge pulse after edge E0+2, serial_o at E0+3.
//     -> all 8 channels toggling simultaneously give independent, correct pulses.

Source files
------------

// File: rtl/sync_edge_filter_pkg.sv
// Shared types and helpers for the multi-channel synchroniser / debounce / edge block.
package sync_edge_filter_pkg;

  // Per-channel edge selection. Bit 0 enables rising edges, bit 1 enables falling edges.
  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // Width of a counter that must hold values 0..debounce. Never narrower than one bit.
  function automatic int cnt_width(input int debounce);
    return (debounce < 1) ? 1 : $clog2(debounce + 1);
  endfunction

endpackage

// File: rtl/sync_edge_filter_ch.sv
// One channel: synchroniser chain, stability counter, filtered level, edge pulses
// qualified by the edge mode, and a sticky pending flag cleared by acknowledge.
module sync_edge_filter_ch
  import sync_edge_filter_pkg::*;
#(
  parameter int STAGES   = 2,
  parameter int DEBOUNCE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic       i_serial,
  input  logic [1:0] i_mode,
  input  logic       i_ack,
  output logic       o_serial,
  output logic       o_r_edge,
  output logic       o_f_edge,
  output logic       o_event,
  output logic       o_pending
);

  localparam int             CW   = cnt_width(DEBOUNCE);
  localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE - 1);

  logic [STAGES-1:0] r_sync;
  logic [CW-1:0]     r_cnt;
  logic              r_filt;
  logic              r_pending;

  logic       w_clear;
  logic       w_s;
  logic       w_mismatch;
  logic       w_accept;
  logic       w_rise;
  logic       w_fall;
  logic       w_event;
  edge_mode_e w_mode;

  assign w_clear    = i_rst | i_clr;
  assign w_s        = r_sync[STAGES-1];
  assign w_mismatch = (w_s != r_filt);
  // The accept condition is the same one that moves r_filt, so the edge pulse
  // is high exactly in the cycle before the filtered level changes.
  assign w_accept   = w_mismatch & i_en & (r_cnt == LAST);
  assign w_rise     = w_accept & w_s;
  assign w_fall     = w_accept & ~w_s;

  assign w_mode  = edge_mode_e'(i_mode);
  assign w_event = (w_rise & ((w_mode == EDGE_RISE) || (w_mode == EDGE_BOTH))) |
                   (w_fall & ((w_mode == EDGE_FALL) || (w_mode == EDGE_BOTH)));

  // Synchroniser chain: shifts every clock, independent of the enable.
  // NOTE: the chain is cleared like any other flop so that a reset restarts
  // qualification from a known 0 level instead of a stale sampled value.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_serial};
    end
  end

  // Stability filter: count enabled cycles of disagreement, accept on the last one;
  // any agreement (glitch returning) restarts the count.
  // NOTE: non-blocking assignments keep every flop updating from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_filt <= 1'b0;
      r_cnt  <= '0;
    end else if (!w_mismatch) begin
      r_cnt  <= '0;
    end else if (i_en) begin
      if (w_accept) begin
        r_filt <= w_s;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

  // Sticky pending flag: a new event wins over a simultaneous acknowledge.
  always_ff @(posedge i_clk) begin
    if (w_clear) begin
      r_pending <= 1'b0;
    end else begin
      r_pending <= w_event | (r_pending & ~i_ack);
    end
  end

  assign o_serial  = r_filt;
  assign o_r_edge  = w_rise;
  assign o_f_edge  = w_fall;
  assign o_event   = w_event;
  assign o_pending = r_pending;

endmodule

// File: rtl/sync_edge_filter.sv
// Multi-channel input conditioner: NUM_CH independent synchronise/debounce/edge
// channels plus a single interrupt line that is the OR of all pending flags.
module sync_edge_filter
  import sync_edge_filter_pkg::*;
#(
  parameter int NUM_CH   = 8,
  parameter int STAGES   = 2,
  parameter int DEBOUNCE = 1
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                clr_i,
  input  logic                en_i,
  input  logic [NUM_CH-1:0]   serial_i,
  input  logic [2*NUM_CH-1:0] mode_i,
  input  logic [NUM_CH-1:0]   ack_i,
  output logic [NUM_CH-1:0]   serial_o,
  output logic [NUM_CH-1:0]   r_edge_o,
  output logic [NUM_CH-1:0]   f_edge_o,
  output logic [NUM_CH-1:0]   event_o,
  output logic [NUM_CH-1:0]   pending_o,
  output logic                irq_o
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sync_edge_filter_ch #(
      .STAGES   (STAGES),
      .DEBOUNCE (DEBOUNCE)
    ) u_ch (
      .i_clk     (clk_i),
      .i_rst     (rst_i),
      .i_clr     (clr_i),
      .i_en      (en_i),
      .i_serial  (serial_i[g]),
      .i_mode    (mode_i[2*g +: 2]),
      .i_ack     (ack_i[g]),
      .o_serial  (serial_o[g]),
      .o_r_edge  (r_edge_o[g]),
      .o_f_edge  (f_edge_o[g]),
      .o_event   (event_o[g]),
      .o_pending (pending_o[g])
    );
  end

  assign irq_o = |pending_o;

endmodule

// File: tb/tb_sync_edge_filter.sv
// Scoreboard bench for sync_edge_filter. Two instances share the same stimulus:
// A (STAGES=2, DEBOUNCE=3) and B (STAGES=3, DEBOUNCE=1, the bypass case).
// The driver predicts each cycle's outputs from a behavioural model and queues
// them; a separate monitor samples the DUTs just before each rising edge and
// compares against the queue.
module tb_sync_edge_filter;
  import sync_edge_filter_pkg::*;

  localparam int NCH = 8;

  typedef struct packed {
    logic [NCH-1:0] serial;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] evt;
    logic [NCH-1:0] pend;
    logic           irq;
  } obs_t;

  logic             clk = 1'b0;
  logic             rst_i, clr_i, en_i;
  logic [NCH-1:0]   serial_i, ack_i;
  logic [2*NCH-1:0] mode_i;

  logic [NCH-1:0] a_serial, a_rise, a_fall, a_evt, a_pend;
  logic           a_irq;
  logic [NCH-1:0] b_serial, b_rise, b_fall, b_evt, b_pend;
  logic           b_irq;

  always #5 clk = ~clk;

  sync_edge_filter #(.NUM_CH(NCH), .STAGES(2), .DEBOUNCE(3)) u_dut_a (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i),
    .serial_i(serial_i), .mode_i(mode_i), .ack_i(ack_i),
    .serial_o(a_serial), .r_edge_o(a_rise), .f_edge_o(a_fall),
    .event_o(a_evt), .pending_o(a_pend), .irq_o(a_irq)
  );

  sync_edge_filter #(.NUM_CH(NCH), .STAGES(3), .DEBOUNCE(1)) u_dut_b (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .en_i(en_i),
    .serial_i(serial_i), .mode_i(mode_i), .ack_i(ack_i),
    .serial_o(b_serial), .r_edge_o(b_rise), .f_edge_o(b_fall),
    .event_o(b_evt), .pending_o(b_pend), .irq_o(b_irq)
  );

  // ---------------- scoreboard state ----------------
  obs_t q_a[$];
  obs_t q_b[$];
  bit   drv_done = 1'b0;
  int   checks   = 0;
  int   errors   = 0;

  // ---------------- next-cycle stimulus ----------------
  logic             nx_rst = 1'b1, nx_clr = 1'b0, nx_en = 1'b1;
  logic [NCH-1:0]   nx_serial = '0, nx_ack = '0, ack_on_event = '0;
  logic [2*NCH-1:0] nx_mode = '0;

  // ---------------- reference model ----------------
  // hist[k] is the input level captured k+1 clocks ago, so the synchroniser
  // output is the level captured STAGES clocks ago. streak counts consecutive
  // enabled cycles in which that synced level disagreed with the accepted level.
  int       stg[2] = '{2, 3};
  int       deb[2] = '{3, 1};
  logic [7:0] m_hist   [2][NCH];
  logic       m_level  [2][NCH];
  int         m_streak [2][NCH];
  logic       m_pend   [2][NCH];

  function automatic bit mode_has_rise(input edge_mode_e m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  function automatic bit mode_has_fall(input edge_mode_e m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        m_hist[d][c]   = '0;
        m_level[d][c]  = 1'b0;
        m_streak[d][c] = 0;
        m_pend[d][c]   = 1'b0;
      end
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict the outputs it should show, then
  // advance the model across the coming rising edge.
  task automatic cycle();
    obs_t       e[2];
    logic       synced [2][NCH];
    logic       moves  [2][NCH];
    logic       ev     [2][NCH];
    edge_mode_e m;
    @(negedge clk);
    rst_i    = nx_rst;
    clr_i    = nx_clr;
    en_i     = nx_en;
    serial_i = nx_serial;
    mode_i   = nx_mode;
    for (int d = 0; d < 2; d++) begin
      e[d] = '0;
      for (int c = 0; c < NCH; c++) begin
        synced[d][c] = m_hist[d][c][stg[d]-1];
        // The level changes at this edge if this is the deb-th enabled disagreeing cycle.
        moves[d][c]  = en_i && (synced[d][c] != m_level[d][c]) && (m_streak[d][c] + 1 >= deb[d]);
        m = edge_mode_e'(nx_mode[2*c +: 2]);
        ev[d][c] = (moves[d][c] && synced[d][c] && mode_has_rise(m)) ||
                   (moves[d][c] && !synced[d][c] && mode_has_fall(m));
        e[d].serial[c] = m_level[d][c];
        e[d].rise[c]   = moves[d][c] && synced[d][c];
        e[d].fall[c]   = moves[d][c] && !synced[d][c];
        e[d].evt[c]    = ev[d][c];
        e[d].pend[c]   = m_pend[d][c];
      end
      e[d].irq = |e[d].pend;
    end
    ack_i = nx_ack | (ack_on_event & e[0].evt);
    q_a.push_back(e[0]);
    q_b.push_back(e[1]);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < NCH; c++) begin
        if (rst_i || clr_i) begin
          m_hist[d][c]   = '0;
          m_level[d][c]  = 1'b0;
          m_streak[d][c] = 0;
          m_pend[d][c]   = 1'b0;
        end else begin
          if (synced[d][c] == m_level[d][c]) m_streak[d][c] = 0;
          else if (moves[d][c]) begin
            m_level[d][c]  = synced[d][c];
            m_streak[d][c] = 0;
          end else if (en_i) m_streak[d][c] = m_streak[d][c] + 1;
          m_pend[d][c] = ev[d][c] || (m_pend[d][c] && !ack_i[c]);
          m_hist[d][c] = {m_hist[d][c][6:0], serial_i[c]};
        end
      end
  endtask

  task automatic hold(input int n);
    repeat (n) cycle();
  endtask

  task automatic set_mode(input int ch, input edge_mode_e m);
    nx_mode[2*ch +: 2] = m;
  endtask

  task automatic run_stimulus();
    // Reset, then idle with everything low.
    nx_rst = 1'b1; hold(2);
    nx_rst = 1'b0; hold(3);

    // Basic path: ch0 rising with mode RISE.
    set_mode(0, EDGE_RISE);
    nx_serial[0] = 1'b1; hold(8);

    // Glitch reject on ch1: 2-cycle pulse is dropped, 3-cycle pulse is accepted.
    set_mode(1, EDGE_BOTH);
    nx_serial[1] = 1'b1; hold(2);
    nx_serial[1] = 1'b0; hold(8);
    nx_serial[1] = 1'b1; hold(3);
    nx_serial[1] = 1'b0; hold(10);

    // Mode mask on ch2: FALL only, then NONE.
    set_mode(2, EDGE_FALL);
    nx_serial[2] = 1'b1; hold(8);
    nx_serial[2] = 1'b0; hold(8);
    set_mode(2, EDGE_NONE);
    nx_serial[2] = 1'b1; hold(8);
    nx_serial[2] = 1'b0; hold(8);

    // Ack race on ch3: ack lands in the same cycle as the event, then one cycle later.
    set_mode(3, EDGE_BOTH);
    ack_on_event = 8'h08;
    nx_serial[3] = 1'b1; hold(8);
    ack_on_event = '0;
    nx_ack = 8'h08; hold(1);
    nx_ack = 8'h00; hold(2);
    nx_ack = 8'hff; hold(1);
    nx_ack = 8'h00; hold(2);

    // Enable gating on ch4, then clear mid-count on ch5 held high.
    set_mode(4, EDGE_BOTH);
    set_mode(5, EDGE_RISE);
    nx_en = 1'b0;
    nx_serial[4] = 1'b1; hold(6);
    nx_en = 1'b1; hold(6);
    nx_serial[5] = 1'b1; hold(3);
    nx_clr = 1'b1; hold(1);
    nx_clr = 1'b0; hold(10);

    // All channels toggling together.
    nx_mode = 16'hffff;
    nx_serial = 8'h00; hold(8);
    nx_serial = 8'hff; hold(8);
    nx_serial = 8'h00; hold(8);
    nx_ack = 8'hff; hold(1);
    nx_ack = 8'h00;

    // Randomised traffic: sparse toggles (and so some glitches), random modes,
    // occasional acks, enable dropouts and rare clears.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 5) == 0) nx_serial[$urandom_range(0, NCH-1)] ^= 1'b1;
      if ($urandom_range(0, 49) == 0) nx_mode = 16'($urandom);
      nx_ack = 8'($urandom & $urandom & $urandom);
      nx_en  = ($urandom_range(0, 7) != 0);
      nx_clr = ($urandom_range(0, 149) == 0);
      cycle();
    end
    nx_ack = '0; nx_clr = 1'b0; nx_en = 1'b1;
    hold(6);

    @(negedge clk);
    drv_done = 1'b1;
  endtask

  task automatic run_monitor();
    obs_t ea, eb;
    wait (q_a.size() > 0);
    forever begin
      #4;
      if (q_a.size() == 0 || q_b.size() == 0) begin
        if (drv_done) break;
        check("scoreboard_empty", 8'd0, 8'd1);
      end else begin
        ea = q_a.pop_front();
        eb = q_b.pop_front();
        check("A.serial_o",  a_serial, ea.serial);
        check("A.r_edge_o",  a_rise,   ea.rise);
        check("A.f_edge_o",  a_fall,   ea.fall);
        check("A.event_o",   a_evt,    ea.evt);
        check("A.pending_o", a_pend,   ea.pend);
        check("A.irq_o",     {7'd0, a_irq}, {7'd0, ea.irq});
        check("B.serial_o",  b_serial, eb.serial);
        check("B.r_edge_o",  b_rise,   eb.rise);
        check("B.f_edge_o",  b_fall,   eb.fall);
        check("B.event_o",   b_evt,    eb.evt);
        check("B.pending_o", b_pend,   eb.pend);
        check("B.irq_o",     {7'd0, b_irq}, {7'd0, eb.irq});
      end
      @(negedge clk);
    end
  endtask

  initial begin
    rst_i    = 1'b1;
    clr_i    = 1'b0;
    en_i     = 1'b1;
    serial_i = '0;
    mode_i   = '0;
    ack_i    = '0;
    model_reset();
    repeat (2) @(posedge clk);
    fork
      run_stimulus();
      run_monitor();
    join
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
